csa_pipe_adder: RTL and testbench
=================================

# csa_pipe_adder

Parametrised, pipelined carry-select adder: WIDTH-bit operands split into BLOCK-bit carry-select segments, one segment resolved per pipeline stage. It is the streaming successor to the 4-bit combinational carry-select adder. It accepts one operand pair per cycle under a valid/ready handshake with full backpressure, and returns {c_out, sum} = a + b + c_in after a fixed latency.

## Interface
Parameters:
- WIDTH, 16, operand/sum width; must be a multiple of BLOCK
- BLOCK, 4, bits per carry-select segment (1..WIDTH); NBLK = WIDTH/BLOCK = pipeline depth

Ports:
- clk  in  1  rising-edge clock (single clock domain)
- rst  in  1  synchronous, active-high reset
- a  in  WIDTH  operand A (unsigned, or two's-complement for overflow)
- b  in  WIDTH  operand B
- c_in  in  1  carry in
- in_valid  in  1  a/b/c_in valid this cycle
- in_ready  out  1  block can accept this cycle
- sum  out  WIDTH  result bits [WIDTH-1:0]
- c_out  out  1  carry out of bit WIDTH-1
- out_valid  out  1  sum/c_out (and overflow) valid
- out_ready  in  1  downstream accepts result
- overflow  out  1  signed overflow flag (present only with CSA_PIPE_OVF_EN)

## Operation
- Synchronous, active-high reset; one clock. On rst=1 at an edge, all stage valid bits, sum, c_out, overflow and all carry registers clear to 0. In-flight data is discarded, including on mid-operation reset. in_ready follows its equation and is 1 once out_valid is 0.
- advance = ~(out_valid & ~out_ready); in_ready = advance. Combinational; never depends on in_valid.
- Transfer in: edge with in_valid & in_ready. Transfer out: edge with out_valid & out_ready.
- Stage k (0..NBLK-1) takes operand bits [k*BLOCK +: BLOCK] and computes two candidate sums, one with carry 0 and one with carry 1. It selects between them with the carry registered by stage k-1; stage 0 uses c_in.
- Operand bits above the current segment travel down skew registers. Resolved low bits travel down alignment registers, so all segments emerge together.
- When advance=1, every stage shifts one step, including bubble stages. There is no bubble collapse. When advance=0, every register holds.
- Arithmetic: {c_out,sum} = a + b + c_in, exact modulo 2^(WIDTH+1). It must match the reference sum for all inputs.
- With in_valid=0 at an advancing edge, a bubble (valid=0) enters stage 0. Data registers may take any value, but out_valid is 0 for that slot.
- BLOCK == WIDTH is legal: a single stage with latency 1.
- An illegal parameter set (WIDTH % BLOCK != 0, or BLOCK < 1) must be a compile/elaboration error.

## Timing
- Latency: a pair accepted at edge n gives out_valid=1 with its result, visible after edge n+NBLK-1. With WIDTH=16, BLOCK=4, the result is visible after the 4th edge counting the accepting edge as the 1st.
- Throughput: one result per cycle while out_ready=1.
- Stall: the result holds stable (sum, c_out, overflow, out_valid) while out_valid=1 and out_ready=0. A pair presented while in_ready=0 is not accepted and must be held by upstream.
- A simultaneous output transfer and input accept in one cycle is legal and lossless.
- rst takes priority over every handshake event at the same edge.

## Configuration
- CSA_PIPE_OVF_EN defined: adds the `overflow` port. overflow = (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]), with a and b registered alongside the result. It is reset to 0 and held under stall like sum.
- Not defined: the port and its sign-bit registers are absent. All other behaviour is identical.

## Test plan
- Exhaustive, WIDTH=4, BLOCK=2: all 512 combinations of a, b and c_in streamed back-to-back with out_ready=1 -> every {c_out,sum} == a+b+c_in, in order, with zero errors.
- Latency, WIDTH=16, BLOCK=4: a=16'hFFFF, b=16'h0000, c_in=1 single-shot -> out_valid rises after the 4th edge with sum=16'h0000 and c_out=1, then drops.
- Backpressure: stream 8 random pairs, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 during the stall, the output is held stable, and no result is lost, duplicated or reordered.
- Bubbles: alternate in_valid 1/0 -> out_valid alternates identically, delayed by NBLK cycles.
- Reset mid-stream: assert rst for 1 cycle with 3 results in flight -> next cycle has out_valid=0, sum=0, c_out=0, and no stale result ever appears.
- CSA_PIPE_OVF_EN, WIDTH=8: a=8'h7F, b=8'h01, c_in=0 -> sum=8'h80, overflow=1. a=8'hFF, b=8'h01 -> sum=8'h00, c_out=1, overflow=0.

Source files
------------

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder: one BLOCK-bit segment resolved per stage, valid/ready flow control.
// Define CSA_PIPE_OVF_EN to add the registered signed-overflow output.
module csa_pipe_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             out_valid,
`ifdef CSA_PIPE_OVF_EN
  output logic             overflow,
`endif
  input  logic             out_ready
);

  if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_params
    $fatal(1, "csa_pipe_adder: WIDTH must be a positive multiple of BLOCK");
  end

  localparam int unsigned NBLK = (BLOCK == 0) ? 1 : WIDTH / BLOCK;

  logic advance;

  assign advance  = ~(out_valid & ~out_ready);
  assign in_ready = advance;

  for (genvar k = 0; k < NBLK; k++) begin : g_stg
    localparam int unsigned LO  = k * BLOCK;
    localparam int unsigned REM = WIDTH - LO;

    logic [REM-1:0]      op_a;
    logic [REM-1:0]      op_b;
    logic                cin;
    logic                vin;
    logic [BLOCK:0]      cand0;
    logic [BLOCK:0]      cand1;
    logic [BLOCK:0]      pick;
    logic [LO+BLOCK-1:0] s_d;
    logic [LO+BLOCK-1:0] s_q;
    logic                c_q;
    logic                v_q;

    if (k == 0) begin : g_head
      assign op_a = a;
      assign op_b = b;
      assign cin  = c_in;
      assign vin  = in_valid;
      assign s_d  = pick[BLOCK-1:0];
    end else begin : g_body
      assign op_a = g_stg[k-1].g_skew.a_q;
      assign op_b = g_stg[k-1].g_skew.b_q;
      assign cin  = g_stg[k-1].c_q;
      assign vin  = g_stg[k-1].v_q;
      assign s_d  = {pick[BLOCK-1:0], g_stg[k-1].s_q};
    end

    // Both carry candidates are formed before the previous stage's carry is known.
    always_comb begin
      cand0 = {1'b0, op_a[BLOCK-1:0]} + {1'b0, op_b[BLOCK-1:0]};
      cand1 = {1'b0, op_a[BLOCK-1:0]} + {1'b0, op_b[BLOCK-1:0]} + (BLOCK+1)'(1);
      pick  = cin ? cand1 : cand0;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= vin;
        c_q <= pick[BLOCK];
        s_q <= s_d;
      end
    end

    if (k < NBLK - 1) begin : g_skew
      logic [REM-BLOCK-1:0] a_q;
      logic [REM-BLOCK-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= op_a[REM-1:BLOCK];
          b_q <= op_b[REM-1:BLOCK];
        end
      end
    end
  end

  assign sum       = g_stg[NBLK-1].s_q;
  assign c_out     = g_stg[NBLK-1].c_q;
  assign out_valid = g_stg[NBLK-1].v_q;

`ifdef CSA_PIPE_OVF_EN
  // Operand sign bits reach the last stage through the skew chain.
  logic sa;
  logic sb;
  logic ovf_d;
  logic ovf_q;

  always_comb begin
    sa    = g_stg[NBLK-1].op_a[BLOCK-1];
    sb    = g_stg[NBLK-1].op_b[BLOCK-1];
    ovf_d = (sa == sb) & (g_stg[NBLK-1].pick[BLOCK-1] != sa);
  end

  always_ff @(posedge clk) begin
    if (rst)          ovf_q <= 1'b0;
    else if (advance) ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Scoreboard bench for csa_pipe_adder: 16/4 main instance plus an exhaustive 4/2 instance.
module tb_csa_pipe_adder;
  localparam int unsigned W  = 16;
  localparam int unsigned B  = 4;
  localparam int unsigned NB = W / B;
  localparam int unsigned W2 = 4;
  localparam int unsigned B2 = 2;

  typedef struct packed { logic [W:0] r; logic o; } exp_t;
  typedef struct packed { logic [W2:0] r; logic o; } exp2_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [W-1:0]  a, b, sum;
  logic          c_in, in_valid, in_ready, out_valid, out_ready, c_out;
  logic [W2-1:0] a2, b2, sum2;
  logic          c2, in_valid2, in_ready2, out_valid2, out_ready2, c_out2;
`ifdef CSA_PIPE_OVF_EN
  logic          ovf, ovf2;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cnt2     = 0;
  exp_t        q[$];
  exp2_t       q2[$];
  logic        stalled = 1'b0;
  logic [W:0]  held_r;
  logic        held_o;
  logic        rnd_done;

  csa_pipe_adder #(.WIDTH(W), .BLOCK(B)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c_in(c_in), .in_valid(in_valid),
    .in_ready(in_ready), .sum(sum), .c_out(c_out), .out_valid(out_valid),
`ifdef CSA_PIPE_OVF_EN
    .overflow(ovf),
`endif
    .out_ready(out_ready)
  );

  csa_pipe_adder #(.WIDTH(W2), .BLOCK(B2)) dut2 (
    .clk(clk), .rst(rst), .a(a2), .b(b2), .c_in(c2), .in_valid(in_valid2),
    .in_ready(in_ready2), .sum(sum2), .c_out(c_out2), .out_valid(out_valid2),
`ifdef CSA_PIPE_OVF_EN
    .overflow(ovf2),
`endif
    .out_ready(out_ready2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: exact integer sum; overflow as signed result out of range.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    exp_t   e;
    longint sx, sy, sr, lim;
    e.r = (W+1)'(x) + (W+1)'(y) + (W+1)'(ci);
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    sr  = sx + sy + longint'(ci);
    lim = longint'(1) << (W - 1);
    e.o = (sr >= lim) || (sr < -lim);
    return e;
  endfunction

  function automatic exp2_t model2(input logic [W2-1:0] x, input logic [W2-1:0] y, input logic ci);
    exp2_t  e;
    longint sx, sy, sr, lim;
    e.r = (W2+1)'(x) + (W2+1)'(y) + (W2+1)'(ci);
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    sr  = sx + sy + longint'(ci);
    lim = longint'(1) << (W2 - 1);
    e.o = (sr >= lim) || (sr < -lim);
    return e;
  endfunction

  // Main monitor: checks handshake equation, stall stability, and pops on every output transfer.
  always @(negedge clk) begin
    exp_t e;
    chk("in_ready_eq", 64'(in_ready), 64'(!(out_valid && !out_ready)));
    if (rst) begin
      q.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_sum", 64'({c_out, sum}), 64'(held_r));
`ifdef CSA_PIPE_OVF_EN
        chk("stall_ovf", 64'(ovf), 64'(held_o));
`endif
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 64'(out_valid), 64'd0);
        end else begin
          e = q.pop_front();
          chk("result", 64'({c_out, sum}), 64'(e.r));
`ifdef CSA_PIPE_OVF_EN
          chk("overflow", 64'(ovf), 64'(e.o));
`endif
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, c_in));
      stalled = out_valid && !out_ready;
      held_r  = {c_out, sum};
`ifdef CSA_PIPE_OVF_EN
      held_o  = ovf;
`else
      held_o  = 1'b0;
`endif
    end
  end

  always @(negedge clk) begin
    exp2_t e;
    if (rst) begin
      q2.delete();
    end else begin
      if (out_valid2 && out_ready2) begin
        cnt2++;
        if (q2.size() == 0) begin
          chk("unexpected_output2", 64'(out_valid2), 64'd0);
        end else begin
          e = q2.pop_front();
          chk("result2", 64'({c_out2, sum2}), 64'(e.r));
`ifdef CSA_PIPE_OVF_EN
          chk("overflow2", 64'(ovf2), 64'(e.o));
`endif
        end
      end
      if (in_valid2 && in_ready2) q2.push_back(model2(a2, b2, c2));
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    int unsigned t = 0;
    logic acc;
    a = x; b = y; c_in = ci; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      acc = in_ready && !rst;
      @(posedge clk);
      #1;
      if (acc) break;
      if (++t > 200) begin
        chk("accept_timeout", 64'd1, 64'd0);
        break;
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] v9;
    logic       vh[16];
    int         idx;
    rst = 1'b1; a = '0; b = '0; c_in = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a2 = '0; b2 = '0; c2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1;
    rnd_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_sum", 64'(sum), 64'd0);
    chk("reset_c_out", 64'(c_out), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid2", 64'(out_valid2), 64'd0);

    // Exhaustive 4-bit, back-to-back.
    for (int i = 0; i < 512; i++) begin
      v9 = 9'(i);
      {a2, b2, c2} = v9;
      in_valid2 = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid2 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("exhaustive_count", 64'(cnt2), 64'd512);
    chk("exhaustive_drained", 64'(q2.size()), 64'd0);

    // Latency: single shot into an empty pipeline.
    send(16'hFFFF, 16'h0000, 1'b1);
    in_valid = 1'b0;
    chk("lat_edge1", 64'(out_valid), 64'd0);
    for (int e = 2; e <= int'(NB) + 1; e++) begin
      @(posedge clk);
      #1;
      chk("lat_valid", 64'(out_valid), 64'(e == int'(NB)));
      if (e == int'(NB)) chk("lat_result", 64'({c_out, sum}), 64'h1_0000);
    end

    // Bubbles: alternate valid, out_valid follows NB-1 edges later.
    idle(NB + 1);
    for (int i = 0; i < 16; i++) begin
      in_valid = (i % 2) == 0;
      a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
      vh[i] = in_valid;
      @(posedge clk);
      #1;
      idx = i - int'(NB) + 1;
      chk("bubble_valid", 64'(out_valid), 64'((idx >= 0) ? vh[idx] : 1'b0));
    end
    idle(NB + 1);

    // Mid-stream reset with three pairs in flight.
    for (int i = 0; i < 3; i++) send(W'($urandom), W'($urandom), 1'($urandom));
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_c_out", 64'(c_out), 64'd0);
`ifdef CSA_PIPE_OVF_EN
    chk("rst_ovf", 64'(ovf), 64'd0);
`endif
    for (int i = 0; i < int'(NB) + 2; i++) begin
      @(posedge clk);
      #1;
      chk("rst_no_stale", 64'(out_valid), 64'd0);
    end

    // Backpressure: 5-cycle stall in the middle of 8 pairs.
    fork
      begin
        for (int i = 0; i < 8; i++) send(W'($urandom), W'($urandom), 1'($urandom));
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #2 out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        repeat (3) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    idle(NB + 2);
    chk("bp_drained", 64'(q.size()), 64'd0);

    // Overflow and carry corner values.
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0);
    send(16'h8000, 16'h8000, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    send(16'h0000, 16'h0000, 1'b0);
    send(16'h7FFF, 16'h0000, 1'b1);
    idle(NB + 2);

    // Random traffic with random idles and random backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(3) == 0) idle(1);
          send(W'($urandom), W'($urandom), 1'($urandom));
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #2 out_ready = ($urandom_range(2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    idle(NB + 3);
    chk("final_drained", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
